// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-controller input stage: keypad geometry,
// key-scan FSM states and the snapshot-bit to digit mapping.
package traffic_pkg;

   localparam int KEY_W    = 10;
   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 3;
   localparam int SNAP_W   = NUM_ROWS * NUM_COLS;
   localparam int IDX_W    = $clog2(SNAP_W);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      EMIT,
      WAIT_RELEASE
   } key_scan_state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] digit;
   } key_digit_t;

   // Snapshot bit = row*3 + col. Rows 0..2 hold 1..9; row 3 holds '*', 0, '#'.
   function automatic key_digit_t snap_to_digit(input logic [IDX_W-1:0] idx);
      key_digit_t r;
      r.valid = 1'b1;
      r.digit = 4'd0;
      if (idx < IDX_W'(9)) begin
         r.digit = idx + 4'd1;
      end else if (idx == IDX_W'(10)) begin
         r.digit = 4'd0;
      end else begin
         r.valid = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/scan_row_timer.sv
// Free-running row-slot timer for the keypad scanner: slot counter, row
// counter, one-cold row drive and the per-slot / per-scan sample strobes.
module scan_row_timer
   import traffic_pkg::*;
#(
   parameter int SCAN_DIV = 1000
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic [$clog2(NUM_ROWS)-1:0] row_idx,
   output logic [NUM_ROWS-1:0]         row_n,
   output logic                        sample_strobe,
   output logic                        scan_done
);

   localparam int ROW_W  = $clog2(NUM_ROWS);
   localparam int SLOT_W = $clog2(SCAN_DIV + 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NUM_ROWS - 1);

   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [ROW_W-1:0]  row_q, row_d;

   assign sample_strobe = (slot_q == SLOT_LAST);
   assign scan_done     = sample_strobe && (row_q == ROW_LAST);
   assign row_idx       = row_q;
   assign row_n         = ~(NUM_ROWS'(1) << row_q);

   always_comb begin
      slot_d = slot_q + SLOT_W'(1);
      row_d  = row_q;
      if (sample_strobe) begin
         slot_d = '0;
         row_d  = row_q + ROW_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= '0;
         row_q  <= '0;
      end else begin
         slot_q <= slot_d;
         row_q  <= row_d;
      end
   end

endmodule

// File: rtl/key_scan_encoder.sv
// 4x3 keypad scanner/debouncer emitting fixed-width one-hot digit pulses.
// Define KEY_SCAN_REPEAT_EN to re-emit a held key every REPEAT_SCANS scans.
module key_scan_encoder
   import traffic_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int HOLD_CYCLES    = 8,
   parameter int REPEAT_SCANS   = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_COLS-1:0] col_n,
   output logic [NUM_ROWS-1:0] row_n,
   output logic [KEY_W-1:0]    Key,
   output logic                busy
);

   localparam int DEB_W  = $clog2(DEBOUNCE_SCANS + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [DEB_W-1:0]  DEB_TARGET = DEB_W'(DEBOUNCE_SCANS);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
   localparam int LOW_W = (NUM_ROWS - 1) * NUM_COLS;

   if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || HOLD_CYCLES < 1 || REPEAT_SCANS < 1) begin : g_bad_params
      $error("key_scan_encoder: parameter below legal minimum");
   end

   logic [$clog2(NUM_ROWS)-1:0] row_idx;
   logic                        sample_strobe;
   logic                        scan_done;

   scan_row_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
      .clk          (clk),
      .rst          (rst),
      .row_idx      (row_idx),
      .row_n        (row_n),
      .sample_strobe(sample_strobe),
      .scan_done    (scan_done)
   );

   logic [NUM_COLS-1:0] col_meta_q, col_sync_q;
   logic [LOW_W-1:0]    row_samples_q;
   logic [SNAP_W-1:0]   snapshot_q;
   logic                snap_valid_q;

   // NOTE: clocked blocks use non-blocking (<=) only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_meta_q    <= '1;
         col_sync_q    <= '1;
         row_samples_q <= '0;
         snapshot_q    <= '0;
         snap_valid_q  <= 1'b0;
      end else begin
         col_meta_q   <= col_n;
         col_sync_q   <= col_meta_q;
         snap_valid_q <= scan_done;
         for (int r = 0; r < NUM_ROWS - 1; r++) begin
            if (sample_strobe && row_idx == 2'(r)) begin
               row_samples_q[r*NUM_COLS +: NUM_COLS] <= ~col_sync_q;
            end
         end
         if (scan_done) begin
            snapshot_q <= {~col_sync_q, row_samples_q};
         end
      end
   end

   key_scan_state_t   state_q, state_d;
   logic [IDX_W-1:0]  cand_q, cand_d;
   logic [DEB_W-1:0]  stable_cnt_q, stable_cnt_d;
   logic [DEB_W-1:0]  rel_cnt_q, rel_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [KEY_W-1:0]  key_q, key_d;
   logic [IDX_W:0]    snap_ones;
   logic [IDX_W-1:0]  snap_idx;
   logic [SNAP_W-1:0] cand_bits;
   key_digit_t        snap_info, cand_info;
   logic              single_digit;

`ifdef KEY_SCAN_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_SCANS + 1);
   localparam logic [REP_W-1:0] REP_TARGET = REP_W'(REPEAT_SCANS);
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             rep_stop_q, rep_stop_d;
`endif

   always_comb begin
      snap_ones = '0;
      snap_idx  = '0;
      for (int i = 0; i < SNAP_W; i++) begin
         if (snapshot_q[i]) begin
            snap_ones = snap_ones + (IDX_W+1)'(1);
            snap_idx  = IDX_W'(i);
         end
      end
      snap_info    = snap_to_digit(snap_idx);
      single_digit = (snap_ones == (IDX_W+1)'(1)) && snap_info.valid;
      cand_bits    = SNAP_W'(1) << cand_q;
   end

   // NOTE: every next-state signal gets a default before the case, so no latches are inferred.
   always_comb begin
      state_d      = state_q;
      cand_d       = cand_q;
      stable_cnt_d = stable_cnt_q;
      rel_cnt_d    = rel_cnt_q;
      hold_cnt_d   = hold_cnt_q;
`ifdef KEY_SCAN_REPEAT_EN
      rep_cnt_d    = rep_cnt_q;
      rep_stop_d   = rep_stop_q;
`endif
      case (state_q)
         SCAN: begin
            if (snap_valid_q && single_digit) begin
               cand_d       = snap_idx;
               stable_cnt_d = DEB_W'(1);
               state_d      = (DEB_W'(1) == DEB_TARGET) ? EMIT : DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (snap_valid_q) begin
               if (snapshot_q == cand_bits) begin
                  stable_cnt_d = stable_cnt_q + DEB_W'(1);
                  if (stable_cnt_d == DEB_TARGET) state_d = EMIT;
               end else begin
                  stable_cnt_d = '0;
                  state_d      = SCAN;
               end
            end
         end
         EMIT: begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if (hold_cnt_q == HOLD_LAST) begin
               hold_cnt_d = '0;
               state_d    = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (snap_valid_q) begin
               if (snapshot_q == '0) begin
                  rel_cnt_d = rel_cnt_q + DEB_W'(1);
`ifdef KEY_SCAN_REPEAT_EN
                  rep_cnt_d = '0;
`endif
                  if (rel_cnt_d == DEB_TARGET) begin
                     rel_cnt_d = '0;
                     state_d   = SCAN;
                  end
               end else begin
                  rel_cnt_d = '0;
`ifdef KEY_SCAN_REPEAT_EN
                  if (snapshot_q == cand_bits && !rep_stop_q) begin
                     rep_cnt_d = rep_cnt_q + REP_W'(1);
                     if (rep_cnt_d == REP_TARGET) state_d = EMIT;
                  end else begin
                     rep_cnt_d  = '0;
                     rep_stop_d = 1'b1;
                  end
`endif
               end
            end
         end
         default: state_d = SCAN;
      endcase

      // Every entry into EMIT starts a fresh pulse with cleared scan counters.
      if (state_d == EMIT && state_q != EMIT) begin
         hold_cnt_d   = '0;
         stable_cnt_d = '0;
         rel_cnt_d    = '0;
`ifdef KEY_SCAN_REPEAT_EN
         rep_cnt_d    = '0;
         if (state_q != WAIT_RELEASE) rep_stop_d = 1'b0;
`endif
      end

      cand_info = snap_to_digit(cand_d);
      key_d     = (state_d == EMIT) ? (KEY_W'(1) << cand_info.digit) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= SCAN;
         cand_q       <= '0;
         stable_cnt_q <= '0;
         rel_cnt_q    <= '0;
         hold_cnt_q   <= '0;
         key_q        <= '0;
`ifdef KEY_SCAN_REPEAT_EN
         rep_cnt_q    <= '0;
         rep_stop_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cand_q       <= cand_d;
         stable_cnt_q <= stable_cnt_d;
         rel_cnt_q    <= rel_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         key_q        <= key_d;
`ifdef KEY_SCAN_REPEAT_EN
         rep_cnt_q    <= rep_cnt_d;
         rep_stop_q   <= rep_stop_d;
`endif
      end
   end

   assign Key  = key_q;
   assign busy = (state_q == EMIT) || (state_q == WAIT_RELEASE);

endmodule

// File: tb/tb_key_scan_encoder.sv
// Randomised scoreboard bench for key_scan_encoder: a keypad model drives the
// columns, a scan-level reference model predicts pulses, a monitor checks them.
`timescale 1ns/1ps
module tb_key_scan_encoder;

   localparam int SCAN_DIV  = 4;
   localparam int DEB       = 2;
   localparam int HOLD      = 3;
   localparam int REP       = 4;
   localparam int SCAN_CLKS = 4 * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  col_n;
   logic [3:0]  row_n;
   logic [9:0]  key;
   logic        busy;
   logic [11:0] pressed;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int digit_of[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -1, 0, -1};

   always #5 clk = ~clk;

   key_scan_encoder #(
      .SCAN_DIV      (SCAN_DIV),
      .DEBOUNCE_SCANS(DEB),
      .HOLD_CYCLES   (HOLD),
      .REPEAT_SCANS  (REP)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .col_n(col_n),
      .row_n(row_n),
      .Key  (key),
      .busy (busy)
   );

   // Passive keypad: a pressed key shorts its column low while its row is driven low.
   always_comb begin
      col_n = 3'b111;
      for (int r = 0; r < 4; r++)
         if (!row_n[r])
            for (int c = 0; c < 3; c++)
               if (pressed[r*3 + c]) col_n[c] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model, advanced once per full scan with that scan's pressed set.
   bit m_busy, m_stop;
   int m_run, m_cand, m_rel, m_rep;

   task automatic model_reset();
      m_busy = 0; m_stop = 0; m_run = 0; m_cand = 0; m_rel = 0; m_rep = 0;
   endtask

   task automatic model_scan(input logic [11:0] s);
      logic [11:0] cand_bit;
      int idx;
      cand_bit = 12'(1) << m_cand;
      if (!m_busy) begin
         if (m_run == 0) begin
            idx = -1;
            for (int i = 0; i < 12; i++) if (s[i]) idx = i;
            if ($countones(s) == 1 && digit_of[idx] >= 0) begin
               m_cand = idx;
               m_run  = 1;
            end
         end else if (s == cand_bit) begin
            m_run++;
         end else begin
            m_run = 0;
         end
         if (m_run == DEB) begin
            exp_q.push_back(digit_of[m_cand]);
            m_busy = 1; m_run = 0; m_rel = 0; m_rep = 0; m_stop = 0;
         end
      end else if (s == '0) begin
         m_rel++;
         m_rep = 0;
         if (m_rel == DEB) begin
            m_busy = 0;
            m_rel  = 0;
         end
      end else begin
         m_rel = 0;
`ifdef KEY_SCAN_REPEAT_EN
         if (s == cand_bit && !m_stop) begin
            m_rep++;
            if (m_rep == REP) begin
               exp_q.push_back(digit_of[m_cand]);
               m_rep = 0;
            end
         end else begin
            m_stop = 1;
            m_rep  = 0;
         end
`endif
      end
   endtask

   // Monitor: every rising edge of OR(Key) pops one expected digit; pulse width is checked at its end.
   logic [9:0] prev_key = '0;
   int  width = 0;
   bit  in_pulse = 0;
   always @(negedge clk) begin
      if (rst) begin
         in_pulse = 0;
         width    = 0;
         prev_key = '0;
      end else begin
         if (key != '0 && prev_key == '0) begin
            in_pulse = 1;
            width    = 1;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: got Key=%b expected none at %0t", key, $time);
            end else begin
               check("pulse_code", 32'(key), 32'(10'(1) << exp_q.pop_front()));
            end
         end else if (key != '0) begin
            width++;
            check("pulse_steady", 32'(key), 32'(prev_key));
         end else if (in_pulse) begin
            check("pulse_width", width, HOLD);
            in_pulse = 0;
         end
         prev_key = key;
      end
   end

   task automatic sync_scan();
      logic [3:0] prev;
      bit found;
      found = 0;
      for (int i = 0; i < 64 && !found; i++) begin
         prev = row_n;
         @(negedge clk);
         if (prev == 4'b0111 && row_n == 4'b1110) found = 1;
      end
      check("scan_sync", 32'(found), 32'd1);
   endtask

   task automatic row_step_check();
      logic [3:0] exp_rows[4];
      exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (i % 4 == 2) check("row_step", 32'(row_n), 32'(exp_rows[i / 4]));
      end
   endtask

   task automatic apply(input logic [11:0] s, input int scans);
      for (int k = 0; k < scans; k++) begin
         pressed = s;
         for (int c = 0; c < SCAN_CLKS; c++) begin
            if (c == 2) check("busy", 32'(busy), 32'(m_busy));
            @(negedge clk);
         end
         model_scan(s);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      rst     = 1'b1;
      pressed = '0;
      repeat (3) @(negedge clk);
      check("reset_row_n", 32'(row_n), 32'(4'b1110));
      check("reset_key",   32'(key),   32'd0);
      check("reset_busy",  32'(busy),  32'd0);
      rst = 1'b0;
      row_step_check();
      sync_scan();

      apply(12'(1) << 4, 3);          // digit 5
      apply('0, 3);
      for (int i = 0; i < 3; i++) begin
         apply(12'(1) << 6, 1);       // digit 7 bouncing
         apply('0, 1);
      end
      apply(12'b000000000101, 3);     // 1 and 3 together
      apply(12'(1) << 9, 3);          // '*'
      apply(12'(1) << 11, 3);         // '#'
      apply('0, 2);
      apply(12'(1) << 8, 20);         // digit 9 held
      apply('0, 3);

      apply(12'(1) << 10, 2);         // digit 0 accepted at the end of this segment
      pressed = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midpulse_key",   32'(key),   32'd0);
      check("midpulse_busy",  32'(busy),  32'd0);
      check("midpulse_row_n", 32'(row_n), 32'(4'b1110));
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      row_step_check();
      sync_scan();
      apply('0, 4);

      for (int n = 0; n < 40; n++) begin
         logic [11:0] s;
         int kind;
         int scans;
         kind  = $urandom_range(0, 4);
         scans = $urandom_range(1, 4);
         case (kind)
            0: s = '0;
            1, 2: s = 12'(1) << $urandom_range(0, 11);
            3: s = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
            default: begin
               s     = 12'(1) << $urandom_range(0, 11);
               scans = $urandom_range(6, 12);
            end
         endcase
         apply(s, scans);
      end

      apply('0, 3);
      repeat (20) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
